// File: rtl/ibex_hpm_counters_if.sv
// CSR access bus between the CS register file (master) and the performance monitor (slave).
interface ibex_hpm_counters_if;
    logic        csr_access_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;

    modport master (
        output csr_access_i, csr_addr_i, csr_wdata_i, csr_op_i,
        input  csr_rdata_o, csr_hit_o
    );

    modport slave (
        input  csr_access_i, csr_addr_i, csr_wdata_i, csr_op_i,
        output csr_rdata_o, csr_hit_o
    );
endinterface

// File: rtl/ibex_hpm_counters.sv
// Programmable hardware performance counters with event masks, inhibit and sticky overflow flags.
// Optional overflow interrupt (CSR 0x7C1 mhpmovfie, ovf_irq_o) enabled by macro IBEX_HPM_OVF_IRQ_EN.
module ibex_hpm_counters #(
    parameter int unsigned N_COUNTERS = 8,
    parameter int unsigned CNT_WIDTH  = 64,
    parameter int unsigned N_EVENTS   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    ibex_hpm_counters_if.slave  csr,
    input  logic [N_EVENTS-1:0] event_i,
    output logic                ovf_irq_o
);
    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam int unsigned IDX_HI  = N_COUNTERS + 2;

    logic [CNT_WIDTH-1:0]  cnt_q  [N_COUNTERS];
    logic [CNT_WIDTH-1:0]  cnt_d  [N_COUNTERS];
    logic [63:0]           cnt_ext[N_COUNTERS];
    logic [N_EVENTS-1:0]   mask_q [N_COUNTERS];
    logic [N_EVENTS-1:0]   mask_d [N_COUNTERS];
    logic [N_COUNTERS-1:0] inh_q, inh_d, ovf_q, ovf_d;
    logic [N_COUNTERS-1:0] inc, wrap;
    logic [N_COUNTERS-1:0] lo_sel, hi_sel, mask_sel;
    logic [N_EVENTS-1:0]   event_q;
    logic                  inh_sel, ovf_sel, hit, we;
    logic [31:0]           rdata, wval;
`ifdef IBEX_HPM_OVF_IRQ_EN
    logic [N_COUNTERS-1:0] ovfie_q;
    logic                  ovfie_sel;
`endif

    always_comb begin
        for (int k = 0; k < N_COUNTERS; k++) cnt_ext[k] = 64'(cnt_q[k]);
    end

    // Address decode and read mux
    always_comb begin
        lo_sel   = '0;
        hi_sel   = '0;
        mask_sel = '0;
        rdata    = '0;
        inh_sel  = (csr.csr_addr_i == 12'h320);
        ovf_sel  = (csr.csr_addr_i == 12'h7C0);
        for (int k = 0; k < N_COUNTERS; k++) begin
            if (csr.csr_addr_i == 12'(32'hB03 + 32'(k))) begin
                lo_sel[k] = 1'b1;
                rdata     = cnt_ext[k][31:0];
            end
            if (csr.csr_addr_i == 12'(32'hB83 + 32'(k))) begin
                hi_sel[k] = 1'b1;
                rdata     = cnt_ext[k][63:32];
            end
            if (csr.csr_addr_i == 12'(32'h323 + 32'(k))) begin
                mask_sel[k] = 1'b1;
                rdata       = 32'(mask_q[k]);
            end
        end
        if (inh_sel) rdata = 32'({inh_q, 3'b000});
        if (ovf_sel) rdata = 32'({ovf_q, 3'b000});
        hit = (|lo_sel) | (|hi_sel) | (|mask_sel) | inh_sel | ovf_sel;
`ifdef IBEX_HPM_OVF_IRQ_EN
        ovfie_sel = (csr.csr_addr_i == 12'h7C1);
        if (ovfie_sel) rdata = 32'({ovfie_q, 3'b000});
        hit = hit | ovfie_sel;
`endif
    end

    assign csr.csr_hit_o   = csr.csr_access_i & hit;
    assign csr.csr_rdata_o = csr.csr_hit_o ? rdata : 32'h0;
    assign we              = csr.csr_hit_o & (csr.csr_op_i != OP_NONE);

    always_comb begin
        unique case (csr.csr_op_i)
            OP_WRITE: wval = csr.csr_wdata_i;
            OP_SET:   wval = rdata | csr.csr_wdata_i;
            default:  wval = rdata & ~csr.csr_wdata_i;
        endcase
    end

    // Next state: a CSR write to a counter half pre-empts that cycle's increment
    always_comb begin
        inh_d = inh_q;
        ovf_d = ovf_q;
        inc   = '0;
        wrap  = '0;
        for (int k = 0; k < N_COUNTERS; k++) begin
            cnt_d[k]  = cnt_q[k];
            mask_d[k] = mask_q[k];
            inc[k]    = (|(event_q & mask_q[k])) & ~inh_q[k];
            if (we && lo_sel[k]) begin
                cnt_d[k] = CNT_WIDTH'({cnt_ext[k][63:32], wval});
            end else if (we && hi_sel[k] && (CNT_WIDTH > 32)) begin
                cnt_d[k] = CNT_WIDTH'({wval, cnt_ext[k][31:0]});
            end else if (inc[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
                wrap[k]  = &cnt_q[k];
            end
            if (we && mask_sel[k]) mask_d[k] = wval[N_EVENTS-1:0];
        end
        if (we && inh_sel) inh_d = wval[IDX_HI:3];
        if (we && ovf_sel) ovf_d = wval[IDX_HI:3];
        ovf_d = ovf_d | wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_COUNTERS; k++) begin
                cnt_q[k]  <= '0;
                mask_q[k] <= '0;
            end
            inh_q   <= '0;
            ovf_q   <= '0;
            event_q <= '0;
        end else begin
            for (int k = 0; k < N_COUNTERS; k++) begin
                cnt_q[k]  <= cnt_d[k];
                mask_q[k] <= mask_d[k];
            end
            inh_q   <= inh_d;
            ovf_q   <= ovf_d;
            event_q <= event_i;
        end
    end

`ifdef IBEX_HPM_OVF_IRQ_EN
    // Interrupt follows the registered flags, so it lags flag/enable changes by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfie_q   <= '0;
            ovf_irq_o <= 1'b0;
        end else begin
            if (we && ovfie_sel) ovfie_q <= wval[IDX_HI:3];
            ovf_irq_o <= |(ovf_q & ovfie_q);
        end
    end
`else
    assign ovf_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_ibex_hpm_counters.sv
// Scoreboard bench for ibex_hpm_counters; follows IBEX_HPM_OVF_IRQ_EN like the design.
module tb_ibex_hpm_counters;
    localparam int unsigned N_COUNTERS = 8;
    localparam int unsigned CNT_WIDTH  = 64;
    localparam int unsigned N_EVENTS   = 16;
    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N_EVENTS-1:0] event_i;
    logic                ovf_irq_o;

    ibex_hpm_counters_if bus ();

    ibex_hpm_counters #(
        .N_COUNTERS(N_COUNTERS),
        .CNT_WIDTH (CNT_WIDTH),
        .N_EVENTS  (N_EVENTS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .csr      (bus.slave),
        .event_i  (event_i),
        .ovf_irq_o(ovf_irq_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [32:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.csr_access_i = 1'b0;
        bus.csr_addr_i   = 12'h0;
        bus.csr_wdata_i  = 32'h0;
        bus.csr_op_i     = OP_NONE;
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
        bus.csr_access_i = 1'b1;
        bus.csr_addr_i   = addr;
        bus.csr_op_i     = op;
        bus.csr_wdata_i  = data;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    // Expected {hit, data} queued at drive time, popped when sampled on the falling edge
    task automatic csr_rd(input string tag, input logic [11:0] addr,
                          input logic exp_hit, input logic [31:0] exp_data);
        logic [32:0] exp;
        exp_q.push_back({exp_hit, exp_data});
        bus.csr_access_i = 1'b1;
        bus.csr_addr_i   = addr;
        bus.csr_op_i     = OP_NONE;
        @(negedge clk);
        exp = exp_q.pop_front();
        check_eq(tag, 64'({bus.csr_hit_o, bus.csr_rdata_o}), 64'(exp));
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic pulse(input logic [N_EVENTS-1:0] ev);
        event_i = ev;
        @(posedge clk);
        #1;
        event_i = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] exp;
        bus_idle();
        event_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_irq", 64'(ovf_irq_o), 64'd0);
        rst_n = 1'b1;

        // Reset values and decode
        csr_rd("rst_inhibit", 12'h320, 1'b1, 32'h0);
        csr_rd("rst_event0",  12'h323, 1'b1, 32'h0);
        csr_rd("rst_lo0",     12'hB03, 1'b1, 32'h0);
        csr_rd("rst_hi0",     12'hB83, 1'b1, 32'h0);
        csr_rd("rst_ovf",     12'h7C0, 1'b1, 32'h0);
        csr_rd("unmapped",    12'h7FF, 1'b0, 32'h0);
        csr_rd("beyond_last", 12'hB0B, 1'b0, 32'h0);

        // Register width masking and the last counter's addresses
        csr_wr(12'h32A, OP_WRITE, 32'hFFFF_FFFF);
        csr_rd("event7_mask", 12'h32A, 1'b1, 32'h0000_FFFF);
        csr_wr(12'h32A, OP_WRITE, 32'h0);
        csr_wr(12'h320, OP_WRITE, 32'hFFFF_FFFF);
        csr_rd("inhibit_bits", 12'h320, 1'b1, 32'h0000_07F8);
        csr_wr(12'h320, OP_CLEAR, 32'hFFFF_FFFF);
        csr_rd("inhibit_clr", 12'h320, 1'b1, 32'h0);
        csr_wr(12'hB0A, OP_WRITE, 32'h1234_5678);
        csr_wr(12'hB8A, OP_WRITE, 32'h0000_CAFE);
        csr_rd("lo7", 12'hB0A, 1'b1, 32'h1234_5678);
        csr_rd("hi7", 12'hB8A, 1'b1, 32'h0000_CAFE);

        // SET op, then latency and single increment per cycle
        csr_wr(12'h323, OP_WRITE, 32'h1);
        csr_wr(12'h323, OP_SET,   32'h2);
        csr_rd("event0_set", 12'h323, 1'b1, 32'h3);
        event_i = 16'h1;
        @(posedge clk);
        #1;
        event_i = 16'h3;
        @(posedge clk);
        #1;
        event_i = '0;
        csr_rd("lat_t2", 12'hB03, 1'b1, 32'h1);
        csr_rd("lat_t3", 12'hB03, 1'b1, 32'h2);

        // 64-bit wrap
        csr_wr(12'hB83, OP_WRITE, 32'hFFFF_FFFF);
        csr_wr(12'hB03, OP_WRITE, 32'hFFFF_FFFE);
        pulse(16'h1);
        csr_rd("pre_wrap_lo", 12'hB03, 1'b1, 32'hFFFF_FFFF);
        pulse(16'h1);
        csr_rd("wrap_lo",  12'hB03, 1'b1, 32'h0);
        csr_rd("wrap_hi",  12'hB83, 1'b1, 32'h0);
        csr_rd("wrap_ovf", 12'h7C0, 1'b1, 32'h8);

        // Inhibit, including an event already in the pipe when inhibit lands
        csr_wr(12'h320, OP_WRITE, 32'h8);
        pulse(16'h1);
        csr_rd("inhibited", 12'hB03, 1'b1, 32'h0);
        csr_wr(12'h320, OP_CLEAR, 32'h8);
        pulse(16'h1);
        csr_rd("uninhibited", 12'hB03, 1'b1, 32'h1);
        event_i = 16'h1;
        csr_wr(12'h320, OP_WRITE, 32'h8);
        event_i = '0;
        @(posedge clk);
        #1;
        csr_wr(12'h320, OP_CLEAR, 32'h8);
        csr_rd("inhibit_inflight", 12'hB03, 1'b1, 32'h1);

        // CSR write versus increment on the same counter
        csr_wr(12'hB83, OP_WRITE, 32'h5);
        event_i = 16'h1;
        @(posedge clk);
        #1;
        event_i = '0;
        csr_wr(12'hB03, OP_WRITE, 32'h100);
        csr_rd("wr_vs_inc_lo", 12'hB03, 1'b1, 32'h100);
        csr_rd("wr_vs_inc_hi", 12'hB83, 1'b1, 32'h5);
        csr_wr(12'hB03, OP_WRITE, 32'hFFFF_FFFF);
        event_i = 16'h1;
        @(posedge clk);
        #1;
        event_i = '0;
        csr_wr(12'hB83, OP_WRITE, 32'h7);
        csr_rd("hiwr_vs_inc_hi", 12'hB83, 1'b1, 32'h7);
        csr_rd("hiwr_vs_inc_lo", 12'hB03, 1'b1, 32'hFFFF_FFFF);

        // Overflow set beats CSR clear
        csr_wr(12'h7C0, OP_CLEAR, 32'h8);
        csr_rd("ovf_cleared", 12'h7C0, 1'b1, 32'h0);
        csr_wr(12'hB83, OP_WRITE, 32'hFFFF_FFFF);
        event_i = 16'h1;
        @(posedge clk);
        #1;
        event_i = '0;
        csr_wr(12'h7C0, OP_CLEAR, 32'h8);
        csr_rd("ovf_set_wins", 12'h7C0, 1'b1, 32'h8);
        csr_rd("ovf_wrap_lo",  12'hB03, 1'b1, 32'h0);

        // Overflow interrupt
        csr_wr(12'h7C0, OP_CLEAR, 32'h8);
        csr_wr(12'hB83, OP_WRITE, 32'hFFFF_FFFF);
        csr_wr(12'hB03, OP_WRITE, 32'hFFFF_FFFF);
`ifdef IBEX_HPM_OVF_IRQ_EN
        csr_wr(12'h7C1, OP_WRITE, 32'h8);
        csr_rd("ovfie_rd", 12'h7C1, 1'b1, 32'h8);
        check_eq("irq_idle", 64'(ovf_irq_o), 64'd0);
        event_i = 16'h1;
        @(posedge clk);
        #1;
        event_i = '0;
        @(posedge clk);
        #1;
        check_eq("irq_lag", 64'(ovf_irq_o), 64'd0);
        @(posedge clk);
        #1;
        check_eq("irq_rise", 64'(ovf_irq_o), 64'd1);
        csr_wr(12'h7C0, OP_CLEAR, 32'h8);
        check_eq("irq_hold", 64'(ovf_irq_o), 64'd1);
        @(posedge clk);
        #1;
        check_eq("irq_fall", 64'(ovf_irq_o), 64'd0);
`else
        csr_rd("ovfie_unmapped", 12'h7C1, 1'b0, 32'h0);
        event_i = 16'h1;
        @(posedge clk);
        #1;
        event_i = '0;
        @(posedge clk);
        #1;
        check_eq("irq_off_a", 64'(ovf_irq_o), 64'd0);
        @(posedge clk);
        #1;
        check_eq("irq_off_b", 64'(ovf_irq_o), 64'd0);
        csr_rd("ovf_no_irq", 12'h7C0, 1'b1, 32'h8);
`endif

        // Asynchronous reset mid-operation
        bus.csr_access_i = 1'b1;
        bus.csr_addr_i   = 12'hB0A;
        bus.csr_op_i     = OP_NONE;
        exp_q.push_back({1'b1, 32'h0});
        #2;
        rst_n = 1'b0;
        #1;
        exp = exp_q.pop_front();
        check_eq("async_rst_lo7", 64'({bus.csr_hit_o, bus.csr_rdata_o}), 64'(exp));
        check_eq("async_rst_irq", 64'(ovf_irq_o), 64'd0);
        bus_idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        csr_rd("post_rst_ovf", 12'h7C0, 1'b1, 32'h0);
        csr_rd("post_rst_hi7", 12'hB8A, 1'b1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
